// File: rtl/spi3w_pkg.sv
// Purpose: shared state encoding, header layout and sync depth for the 3-wire SPI responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi3w_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    WR_DATA = 3'd2,
    RD_DATA = 3'd3,
    WAIT_CS = 3'd4
  } state_t;

  // Header layout {R/W, W1, W0, A[12:0]}
  localparam int RW_BIT = 15;
  localparam int W_MSB  = 14;
  localparam int W_LSB  = 13;

  // Flops per pad synchronizer (sclk gets one more for edge detection)
  localparam int SCLK_SYNC_STAGES = 2;

endpackage

// File: rtl/spi3w_slave_regs_if.sv
// Purpose: SPI pad signals plus the exported register-write strobe port.
// Latency: n/a (wiring only).
// Backpressure: none; the write strobe is fire-and-forget.
interface spi3w_slave_regs_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
);
  logic                  spi_sclk;
  logic                  spi_cs_n;
  logic                  sdio_in;
  logic                  sdio_out;
  logic                  sdio_t;
  logic                  o_reg_wr_en;
  logic [ADDR_WIDTH-1:0] o_reg_addr;
  logic [DATA_WIDTH-1:0] o_reg_wr_data;
  logic                  o_busy;

  modport slave (
    input  spi_sclk, spi_cs_n, sdio_in,
    output sdio_out, sdio_t, o_reg_wr_en, o_reg_addr, o_reg_wr_data, o_busy
  );

  modport master (
    output spi_sclk, spi_cs_n, sdio_in,
    input  sdio_out, sdio_t, o_reg_wr_en, o_reg_addr, o_reg_wr_data, o_busy
  );
endinterface

// File: rtl/spi3w_pin_sync.sv
// Purpose: synchronize sclk/cs_n/sdio into clk_20 and derive one-cycle sclk rise/fall pulses.
// Latency: pad edge to pulse consumed on the 3rd clk_20 edge.
// Backpressure: none; every sampled edge produces exactly one pulse.
module spi3w_pin_sync
  import spi3w_pkg::*;
(
  input  logic clk_20,
  input  logic rst,
  input  logic spi_sclk,
  input  logic spi_cs_n,
  input  logic sdio_in,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_n_s,
  output logic sdio_s
);

  logic [SCLK_SYNC_STAGES-1:0] sclk_ff;
  logic [SCLK_SYNC_STAGES-1:0] cs_ff;
  logic [SCLK_SYNC_STAGES-1:0] sdio_ff;
  logic                        sclk_d;

  // Two-flop synchronizers; cs resets deasserted so nothing looks selected in reset
  always_ff @(posedge clk_20) begin
    if (rst) begin
      sclk_ff <= '0;
      cs_ff   <= '1;
      sdio_ff <= '0;
      sclk_d  <= 1'b0;
    end else begin
      sclk_ff <= {sclk_ff[SCLK_SYNC_STAGES-2:0], spi_sclk};
      cs_ff   <= {cs_ff[SCLK_SYNC_STAGES-2:0], spi_cs_n};
      sdio_ff <= {sdio_ff[SCLK_SYNC_STAGES-2:0], sdio_in};
      sclk_d  <= sclk_ff[SCLK_SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_ff[SCLK_SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_ff[SCLK_SYNC_STAGES-1] & sclk_d;
  assign cs_n_s    = cs_ff[SCLK_SYNC_STAGES-1];
  assign sdio_s    = sdio_ff[SCLK_SYNC_STAGES-1];

endmodule

// File: rtl/spi3w_slave_regs.sv
// Purpose: 3-wire SPI responder with local register file; W=11 streaming enabled by SPI3W_SLAVE_STREAM_EN.
// Latency: write strobe 1 cycle after the synchronized 8th rise; SDIO driven 1 cycle after each sync fall.
// Backpressure: none; the master owns timing, strobes cannot be stalled.
module spi3w_slave_regs
  import spi3w_pkg::*;
#(
  parameter int ADDR_WIDTH       = 13,
  parameter int DATA_WIDTH       = 8,
  parameter int INSTR_HEADER_LEN = 16,
  parameter int NUM_REGS         = 16
)(
  input  logic                clk_20,
  input  logic                rst,
  spi3w_slave_regs_if.slave   bus
);

`ifdef SPI3W_SLAVE_STREAM_EN
  localparam bit STREAM_EN = 1'b1;
`else
  localparam bit STREAM_EN = 1'b0;
`endif

  localparam int         IDX_W     = $clog2(NUM_REGS);
  localparam logic [4:0] HDR_LAST  = 5'(INSTR_HEADER_LEN - 1);
  localparam logic [4:0] BYTE_LAST = 5'(DATA_WIDTH - 1);
  localparam logic [4:0] BYTE_BITS = 5'(DATA_WIDTH);

  logic sclk_rise, sclk_fall, cs_n_s, sdio_s;

  state_t                      state;
  logic [4:0]                  bit_cnt;
  logic [INSTR_HEADER_LEN-1:0] shreg;
  logic [DATA_WIDTH-1:0]       rd_shreg;
  logic [ADDR_WIDTH-1:0]       addr;
  logic [1:0]                  bytes_left;
  logic                        stream;
  logic [DATA_WIDTH-1:0]       regs [NUM_REGS];

  logic                  sdio_out_q, sdio_t_q, wr_en_q, busy_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic [INSTR_HEADER_LEN-1:0] hdr_next;
  logic [DATA_WIDTH-1:0]       byte_next;
  logic [ADDR_WIDTH-1:0]       hdr_addr, addr_dec;
  logic [1:0]                  hdr_w;
  logic [DATA_WIDTH-1:0]       rd_hdr_val, rd_dec_val;

  spi3w_pin_sync u_pin_sync (
    .clk_20    (clk_20),
    .rst       (rst),
    .spi_sclk  (bus.spi_sclk),
    .spi_cs_n  (bus.spi_cs_n),
    .sdio_in   (bus.sdio_in),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_n_s    (cs_n_s),
    .sdio_s    (sdio_s)
  );

  // Shift-in view of the current bit plus decoded header fields
  assign hdr_next  = {shreg[INSTR_HEADER_LEN-2:0], sdio_s};
  assign byte_next = {shreg[DATA_WIDTH-2:0], sdio_s};
  assign hdr_addr  = hdr_next[ADDR_WIDTH-1:0];
  assign hdr_w     = hdr_next[W_MSB:W_LSB];
  assign addr_dec  = addr - 1'b1;

  // Out-of-range addresses read back as zero
  assign rd_hdr_val = (hdr_addr < ADDR_WIDTH'(NUM_REGS)) ? regs[hdr_addr[IDX_W-1:0]] : '0;
  assign rd_dec_val = (addr_dec < ADDR_WIDTH'(NUM_REGS)) ? regs[addr_dec[IDX_W-1:0]] : '0;

  // Protocol FSM, register file and all registered outputs; reset beats a same-cycle write
  always_ff @(posedge clk_20) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      rd_shreg   <= '0;
      addr       <= '0;
      bytes_left <= '0;
      stream     <= 1'b0;
      sdio_out_q <= 1'b0;
      sdio_t_q   <= 1'b1;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_en_q <= 1'b0;
      busy_q  <= ~cs_n_s;
      if (cs_n_s) begin
        state    <= IDLE;
        sdio_t_q <= 1'b1;
        bit_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            state   <= HEADER;
          end
          HEADER: if (sclk_rise) begin
            shreg   <= hdr_next;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == HDR_LAST) begin
              bit_cnt    <= '0;
              addr       <= hdr_addr;
              bytes_left <= hdr_w;
              stream     <= (hdr_w == 2'b11);
              rd_shreg   <= rd_hdr_val;
              if (hdr_w == 2'b11 && !STREAM_EN) state <= WAIT_CS;
              else if (hdr_next[RW_BIT])        state <= RD_DATA;
              else                              state <= WR_DATA;
            end
          end
          WR_DATA: if (sclk_rise) begin
            shreg   <= hdr_next;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BYTE_LAST) begin
              bit_cnt <= '0;
              addr    <= addr_dec;
              if (addr < ADDR_WIDTH'(NUM_REGS)) begin
                regs[addr[IDX_W-1:0]] <= byte_next;
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr;
                wr_data_q <= byte_next;
              end
              if (!stream && bytes_left == 2'd0) state <= WAIT_CS;
              else bytes_left <= bytes_left - 1'b1;
            end
          end
          RD_DATA: begin
            if (sclk_fall && bit_cnt != BYTE_BITS) begin
              sdio_out_q <= rd_shreg[DATA_WIDTH-1];
              rd_shreg   <= rd_shreg << 1;
              sdio_t_q   <= 1'b0;
              bit_cnt    <= bit_cnt + 1'b1;
            end else if (sclk_rise && bit_cnt == BYTE_BITS) begin
              bit_cnt  <= '0;
              addr     <= addr_dec;
              rd_shreg <= rd_dec_val;
              if (!stream && bytes_left == 2'd0) begin
                state    <= WAIT_CS;
                sdio_t_q <= 1'b1;
              end else begin
                bytes_left <= bytes_left - 1'b1;
              end
            end
          end
          WAIT_CS: sdio_t_q <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Release the pad the same cycle the synchronized deselect is seen
  assign bus.sdio_t        = sdio_t_q | cs_n_s;
  assign bus.sdio_out      = sdio_out_q;
  assign bus.o_reg_wr_en   = wr_en_q;
  assign bus.o_reg_addr    = wr_addr_q;
  assign bus.o_reg_wr_data = wr_data_q;
  assign bus.o_busy        = busy_q;

endmodule

// File: tb/tb_spi3w_slave_regs.sv
// Purpose: self-checking bench for spi3w_slave_regs (table vectors, corner sequences, random vs model).
// Latency: SCLK half period of 6 clk_20 cycles.
// Backpressure: n/a.
module tb_spi3w_slave_regs;
  import spi3w_pkg::*;

  localparam int HALF = 6;
`ifdef SPI3W_SLAVE_STREAM_EN
  localparam bit STREAM = 1'b1;
`else
  localparam bit STREAM = 1'b0;
`endif

  // Data bytes packed {b3,b2,b1,b0}: b0 is the first byte on the wire
  typedef struct {
    logic [15:0]       hdr;
    int                nb;
    logic [31:0]       wd;
    int                ns;
    logic [3:0][20:0]  es;
    logic [31:0]       rd;
  } vec_t;

  logic clk_20 = 1'b0;
  logic rst;
  logic m_drv;
  always #5 clk_20 = ~clk_20;

  spi3w_slave_regs_if bus();
  assign bus.sdio_in = bus.sdio_t ? m_drv : bus.sdio_out;

  spi3w_slave_regs dut (
    .clk_20 (clk_20),
    .rst    (rst),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [20:0] stb_q[$];
  logic [20:0] exp_q[$];
  int t_low_total = 0;
  int run = 0;
  int max_run = 0;
  logic [7:0] mdl [16];

  // Monitor: collect strobes, measure pulse width and pad-drive activity
  always @(negedge clk_20) begin
    if (!bus.sdio_t) t_low_total++;
    if (bus.o_reg_wr_en) begin
      stb_q.push_back({bus.o_reg_addr, bus.o_reg_wr_data});
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [20:0] s(input logic [12:0] a, input logic [7:0] d);
    return {a, d};
  endfunction

  task automatic spi_bit(input logic b, output logic r);
    m_drv = b;
    repeat (HALF) @(negedge clk_20);
    bus.spi_sclk = 1'b1;
    r = bus.sdio_in;
    repeat (HALF) @(negedge clk_20);
    bus.spi_sclk = 1'b0;
  endtask

  task automatic spi_txn(input logic [15:0] hdr, input int dbits, input logic [31:0] wd,
                         output logic [31:0] rd);
    logic r;
    int idx;
    rd = '0;
    @(negedge clk_20);
    bus.spi_cs_n = 1'b0;
    repeat (4) @(negedge clk_20);
    for (int i = 0; i < 16; i++) spi_bit(hdr[15-i], r);
    chk("busy_mid", bus.o_busy, 1);
    for (int i = 0; i < dbits; i++) begin
      idx = (i / 8) * 8 + 7 - (i % 8);
      spi_bit(wd[idx], r);
      rd[idx] = r;
    end
    repeat (HALF) @(negedge clk_20);
    bus.spi_cs_n = 1'b1;
    repeat (8) @(negedge clk_20);
  endtask

  // Reference: byte count from W, address counts down modulo 2^13, 16 real registers
  task automatic model_txn(input logic [15:0] hdr, input int nb, input logic [31:0] wd,
                           output int n, output logic [31:0] er);
    int a;
    logic [1:0] w;
    w = hdr[14:13];
    er = '0;
    exp_q.delete();
    if (w == 2'b11) n = STREAM ? nb : 0;
    else n = int'(w) + 1;
    for (int i = 0; i < n; i++) begin
      a = (int'(hdr[12:0]) - i + 8192) % 8192;
      if (hdr[15]) begin
        er[i*8 +: 8] = (a < 16) ? mdl[a] : 8'h00;
      end else if (a < 16) begin
        exp_q.push_back({13'(a), wd[i*8 +: 8]});
        mdl[a] = wd[i*8 +: 8];
      end
    end
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_sdio_out"}, bus.sdio_out, 0);
    chk({nm, "_sdio_t"},   bus.sdio_t, 1);
    chk({nm, "_wr_en"},    bus.o_reg_wr_en, 0);
    chk({nm, "_addr"},     bus.o_reg_addr, 0);
    chk({nm, "_data"},     bus.o_reg_wr_data, 0);
    chk({nm, "_busy"},     bus.o_busy, 0);
  endtask

  vec_t vecs[10];

  initial begin
    logic [31:0] rd, er;
    int start, t0, n, nb, sel, a;
    logic [15:0] hdr;
    logic [1:0] w;
    logic rw;
    logic [31:0] wd, mask;

    vecs[0] = '{16'h0005, 1, 32'h3A, 1, {21'h0, 21'h0, 21'h0, s(13'h005, 8'h3A)}, 32'h0};
    vecs[1] = '{16'h8005, 1, 32'h0, 0, '0, 32'h3A};
    vecs[2] = '{16'h4007, 3, 32'h00332211, 3,
                {21'h0, s(13'h005, 8'h33), s(13'h006, 8'h22), s(13'h007, 8'h11)}, 32'h0};
    vecs[3] = '{16'hC007, 3, 32'h0, 0, '0, 32'h00332211};
    vecs[4] = '{16'h0100, 1, 32'h55, 0, '0, 32'h0};
    vecs[5] = '{16'h8100, 1, 32'h0, 0, '0, 32'h0};
    vecs[6] = '{16'h2000, 2, 32'h00008877, 1, {21'h0, 21'h0, 21'h0, s(13'h000, 8'h77)}, 32'h0};
    vecs[7] = '{16'hA000, 2, 32'h0, 0, '0, 32'h00000077};
    vecs[8] = '{16'h6003, 4, 32'hD4C3B2A1, STREAM ? 4 : 0,
                {s(13'h000, 8'hD4), s(13'h001, 8'hC3), s(13'h002, 8'hB2), s(13'h003, 8'hA1)}, 32'h0};
    vecs[9] = '{16'h8003, 1, 32'h0, 0, '0, STREAM ? 32'hA1 : 32'h00};

    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    rst = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    m_drv = 1'b0;
    repeat (5) @(negedge clk_20);
    check_reset("rst0");
    rst = 1'b0;
    repeat (5) @(negedge clk_20);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      start = stb_q.size();
      t0 = t_low_total;
      spi_txn(vecs[i].hdr, vecs[i].nb * 8, vecs[i].wd, rd);
      if (vecs[i].hdr[15]) begin
        chk($sformatf("tbl%0d_rd", i), rd, vecs[i].rd);
        chk($sformatf("tbl%0d_drive", i), 32'(t_low_total - t0 > 0), 1);
      end else begin
        chk($sformatf("tbl%0d_nodrive", i), 32'(t_low_total - t0), 0);
      end
      chk($sformatf("tbl%0d_nstb", i), 32'(stb_q.size() - start), 32'(vecs[i].ns));
      for (int k = 0; k < vecs[i].ns; k++)
        if (start + k < stb_q.size())
          chk($sformatf("tbl%0d_stb%0d", i, k), 32'(stb_q[start+k]), 32'(vecs[i].es[k]));
      chk($sformatf("tbl%0d_release", i), bus.sdio_t, 1);
      chk($sformatf("tbl%0d_idle_busy", i), bus.o_busy, 0);
      model_txn(vecs[i].hdr, vecs[i].nb, vecs[i].wd, n, er);
    end

    // Abort after 4 data bits: nothing written, back to IDLE, next transaction works
    start = stb_q.size();
    spi_txn(16'h0009, 4, 32'hF0, rd);
    chk("abort_nstb", 32'(stb_q.size() - start), 0);
    chk("abort_state", 32'(dut.state), 32'(IDLE));
    chk("abort_busy", bus.o_busy, 0);
    spi_txn(16'h8009, 8, 32'h0, rd);
    chk("abort_reg_kept", rd, 32'h0);
    start = stb_q.size();
    spi_txn(16'h0009, 8, 32'h5C, rd);
    chk("after_abort_nstb", 32'(stb_q.size() - start), 1);
    if (stb_q.size() > start) chk("after_abort_stb", 32'(stb_q[start]), 32'(s(13'h009, 8'h5C)));
    spi_txn(16'h8009, 8, 32'h0, rd);
    chk("after_abort_rd", rd, 32'h5C);
    mdl[9] = 8'h5C;

    // Random transactions against the model
    for (int t = 0; t < 30; t++) begin
      rw  = 1'($urandom_range(0, 1));
      w   = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = $urandom_range(0, 19);
      else if (sel == 8) a = $urandom_range(8190, 8191);
      else               a = 32'h100;
      hdr = {rw, w, 13'(a)};
      nb  = (w == 2'b11) ? $urandom_range(1, 4) : int'(w) + 1;
      wd  = $urandom;
      model_txn(hdr, nb, wd, n, er);
      start = stb_q.size();
      t0 = t_low_total;
      spi_txn(hdr, nb * 8, wd, rd);
      chk($sformatf("rnd%0d_nstb", t), 32'(stb_q.size() - start), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++)
        if (start + k < stb_q.size())
          chk($sformatf("rnd%0d_stb%0d", t, k), 32'(stb_q[start+k]), 32'(exp_q[k]));
      if (rw && n > 0) begin
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
        chk($sformatf("rnd%0d_rd", t), rd & mask, er);
      end
      chk($sformatf("rnd%0d_drive", t), 32'(t_low_total - t0 > 0), 32'(rw && n > 0));
    end

    chk("wr_en_width", 32'(max_run), 1);

    // Reset clears outputs and the register file
    @(negedge clk_20);
    rst = 1'b1;
    repeat (3) @(negedge clk_20);
    check_reset("rst1");
    rst = 1'b0;
    repeat (3) @(negedge clk_20);
    spi_txn(16'h8005, 8, 32'h0, rd);
    chk("rst_clears_reg", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi3w_slave_regs.md
# spi3w_slave_regs

Synthesizable 3-wire SPI responder: the device side of the shared-SDIO, 16-bit-header configuration protocol our SPI master drives toward the AD9517 and the ADCs. It oversamples SCLK/CS_N/SDIO on clk_20, decodes the instruction header, and serves reads and writes to a local register file. Write strobes are exported to fabric logic. It is used as the bench's device model and as the FPGA-side config port for daughter-board control.

## Interface
- ADDR_WIDTH, 13: address field width in the header.
- DATA_WIDTH, 8: bits per data byte.
- INSTR_HEADER_LEN, 16: header length; layout {R/W, W1, W0, A[12:0]}.
- NUM_REGS, 16: implemented registers at addresses 0..NUM_REGS-1.
- clk_20  in  1  system clock; reset rst (synchronous, active-high); clock clk_20.
- rst  in  1  synchronous active-high reset.
- spi_sclk  in  1  SPI clock from the master, CPOL=0, asynchronous to clk_20.
- spi_cs_n  in  1  chip select, active-low.
- sdio_in  in  1  SDIO pad input (IOBUF O).
- sdio_out  out  1  SDIO drive value (IOBUF I).
- sdio_t  out  1  IOBUF tristate: 1 = input (release), 0 = drive.
- o_reg_wr_en  out  1  one-cycle strobe per completed write byte.
- o_reg_addr  out  ADDR_WIDTH  address of the strobed write.
- o_reg_wr_data  out  DATA_WIDTH  data of the strobed write.
- o_busy  out  1  high while CS_N is low (synchronized).

## Operation
- Input path: each of sclk, cs_n, and sdio_in passes through a 2-FF synchronizer. A third flop on sclk gives rise/fall pulses.
- Bit order: MSB first. The slave samples SDIO on the SCLK rise and changes SDIO on the SCLK fall.
- Header fields: R/W = 1 means read. W[1:0] gives the byte count: 00 = 1, 01 = 2, 10 = 3, 11 = streaming.
- Address handling: the address decrements by 1 after each byte. It wraps from 0 to 2^ADDR_WIDTH-1.
- Out-of-range addresses (≥ NUM_REGS): writes are dropped with no strobe; reads return 0x00.
- States:
  - IDLE: waits for CS_N low, then clears the bit counter → HEADER.
  - HEADER: shifts 16 bits on rises. On the 16th rise it latches the header, then → WR_DATA (R/W = 0) or RD_DATA (R/W = 1).
  - WR_DATA: shifts 8 bits. On the 8th rise it writes the register file, pulses o_reg_wr_en, and decrements the address. The byte counter then exhausted → WAIT_CS; otherwise it stays.
  - RD_DATA: loads the shift register with reg[addr] at header completion. On each fall it drives the next MSB with sdio_t = 0. After the 8th fall's bit, the next rise advances the byte; when the count is exhausted → WAIT_CS.
  - WAIT_CS: ignores SCLK, keeps sdio_t = 1, and returns to IDLE on CS_N high.
- CS_N high in any state → IDLE. sdio_t goes to 1 in the same clk_20 cycle the synchronized CS_N rise is seen. A partial byte is discarded with no strobe.
- Simultaneous events: a register-file write from SPI and a reset in the same cycle → reset wins.

## Timing
- Reset values: sdio_out 0, sdio_t 1, o_reg_wr_en 0, o_reg_addr 0, o_reg_wr_data 0, o_busy 0, all registers 0, state IDLE.
- Pin-to-event latency: 3 clk_20 cycles from a pad edge to the internal rise/fall pulse.
- o_reg_wr_en asserts 1 cycle after the internal 8th-rise pulse, for exactly 1 cycle.
- Read turnaround: sdio_t falls 1 cycle after the internal fall pulse that follows the 16th rise. The first data bit is valid at that time.
- Requirement: SCLK high and low phases must each be ≥ 4 clk_20 cycles. The nominal master runs SCLK = clk_20/64.
- A CS_N setup to first rise shorter than 3 clk_20 cycles is unsupported.

## Configuration
- SPI3W_SLAVE_STREAM_EN defined: W = 11 streams bytes, decrementing the address, until CS_N rises.
- Not defined: a W = 11 header is rejected after the 16th rise → WAIT_CS. There are no writes, no strobes, and sdio_t stays 1.

## Structure
- Package spi3w_pkg holds:
  - the state enum (IDLE, HEADER, WR_DATA, RD_DATA, WAIT_CS);
  - header bit positions RW_BIT = 15, W_MSB = 14, W_LSB = 13;
  - localparam SCLK_SYNC_STAGES = 2.
- Sub-module spi3w_pin_sync holds the three synchronizers plus SCLK rise/fall detection, instantiated once.

## Test plan
- Write 0x3A to addr 0x005 (header 0x0005, W = 00) → one o_reg_wr_en pulse with addr 0x005 and data 0x3A; reg[5] = 0x3A.
- Read addr 0x005 after the above (header 0x8005) → sdio_t = 0 for 8 SCLK periods, master captures 0x3A, sdio_t = 1 after CS_N high.
- 3-byte write (header 0x4007, data 0x11, 0x22, 0x33) → strobes to 0x007, 0x006, 0x005 in order.
- Write to addr 0x100 → no strobe; readback of 0x100 returns 0x00.
- CS_N raised after 4 data bits of a write → no strobe, state IDLE, register unchanged; the next full transaction succeeds.
- Header 0x6003 with 4 data bytes:
  - with SPI3W_SLAVE_STREAM_EN → 4 strobes to 0x003..0x000;
  - without it → zero strobes.
